sb_thres_servo: RTL

Closed-loop threshold controller for the 40 MHz single-bin trigger path. Per PMT, it counts threshold crossings over a programmable window of downsampled samples. After each window it steps each THRES up or down to bring the crossing count within TARGET ± TOL. It then drives THRES0..2 into the single-bin trigger. It runs in the CLK120 domain and uses the same ENABLE40 phase, so thresholds change only on downsample boundaries.

---
 rtl/sb_thres_servo.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/sb_thres_servo.sv
// sb_thres_servo: closed-loop per-PMT threshold servo for the single-bin trigger.
// Counts threshold crossings over a window of 40 MHz samples and steps each
// THRESn up or down until the count sits inside TARGET +/- TOL.
// Optional feature macro: SB_SERVO_BISECT_EN (per-PMT halving step on reversal).
module sb_thres_servo #(
   parameter int ADC_W    = 12,
   parameter int CNT_W    = 16,
   parameter int WIN_W    = 24,
   parameter int MAX_ITER = 64
) (
   input  logic             CLK120,
   input  logic             RSTN,
   input  logic [1:0]       ENABLE40,
   input  logic [ADC_W-1:0] ADC0,
   input  logic [ADC_W-1:0] ADC1,
   input  logic [ADC_W-1:0] ADC2,
   input  logic             START,
   input  logic             ABORT,
   input  logic [ADC_W-1:0] INIT_THRES,
   input  logic [ADC_W-1:0] STEP,
   input  logic [CNT_W-1:0] TARGET,
   input  logic [CNT_W-1:0] TOL,
   input  logic [WIN_W-1:0] WINDOW,
   output logic [ADC_W-1:0] THRES0,
   output logic [ADC_W-1:0] THRES1,
   output logic [ADC_W-1:0] THRES2,
   output logic             BUSY,
   output logic             DONE,
   output logic [2:0]       LOCKED,
   output logic             FAIL
);

   localparam int IT_W = $clog2(MAX_ITER + 1);
   localparam logic [IT_W-1:0] MAX_IT = IT_W'(MAX_ITER);

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_MEASURE, S_ADJUST, S_CHECK, S_FINISH
   } state_t;

   state_t                      state_q, state_d;
   logic [1:0]                  en40_q;
   logic [2:0][ADC_W-1:0]       adc_q;
   logic [2:0][ADC_W-1:0]       thres_q, thres_d;
   logic [2:0][CNT_W-1:0]       cnt_q, cnt_d;
   logic [2:0]                  prev_q, prev_d;
   logic [2:0]                  locked_q, locked_d;
   logic                        fail_q, fail_d;
   logic [IT_W-1:0]             iter_q, iter_d;
   logic [WIN_W-1:0]            win_q, win_d;
   logic                        settle_q, settle_d;
   logic [WIN_W-1:0]            window_q, window_d;
   logic [CNT_W-1:0]            target_q, target_d;
   logic [CNT_W-1:0]            tol_q, tol_d;
`ifdef SB_SERVO_BISECT_EN
   logic [2:0][ADC_W-1:0]       pstep_q, pstep_d;
   logic [2:0]                  dir_q, dir_d;    // 1 = last move was up
   logic [2:0]                  dirv_q, dirv_d;  // a last direction exists
   logic [ADC_W-1:0]            stp_h;
`else
   logic [ADC_W-1:0]            step_q, step_d;
`endif

   logic                        strobe;
   logic [ADC_W-1:0]            step_eff;
   logic [CNT_W:0]              hi_band;
   logic                        above, up, dn;
   logic [ADC_W-1:0]            stp;
   logic [ADC_W:0]              sum;

   assign strobe   = (en40_q == 2'd0);
   assign step_eff = (STEP == '0) ? ADC_W'(1) : STEP;
   assign hi_band  = {1'b0, target_q} + {1'b0, tol_q};

   // Local registering of the phase and sample inputs.
   always_ff @(posedge CLK120 or negedge RSTN) begin
      if (!RSTN) begin
         en40_q <= '0;
         adc_q  <= '0;
      end else begin
         en40_q <= ENABLE40;
         adc_q  <= {ADC2, ADC1, ADC0};
      end
   end

   // Next-state and datapath for the servo FSM.
   always_comb begin
      state_d  = state_q;
      thres_d  = thres_q;
      cnt_d    = cnt_q;
      prev_d   = prev_q;
      locked_d = locked_q;
      fail_d   = fail_q;
      iter_d   = iter_q;
      win_d    = win_q;
      settle_d = settle_q;
      window_d = window_q;
      target_d = target_q;
      tol_d    = tol_q;
`ifdef SB_SERVO_BISECT_EN
      pstep_d  = pstep_q;
      dir_d    = dir_q;
      dirv_d   = dirv_q;
      stp_h    = '0;
`else
      step_d   = step_q;
`endif
      above    = 1'b0;
      up       = 1'b0;
      dn       = 1'b0;
      stp      = '0;
      sum      = '0;

      // ABORT outranks everything, including a window that ends this cycle.
      if (ABORT && state_q != S_IDLE) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (START) begin
                  thres_d  = {3{INIT_THRES}};
                  locked_d = '0;
                  fail_d   = 1'b0;
                  iter_d   = '0;
                  cnt_d    = '0;
                  prev_d   = '0;
                  settle_d = 1'b0;
                  win_d    = '0;
                  window_d = (WINDOW == '0) ? WIN_W'(1) : WINDOW;
                  target_d = TARGET;
                  tol_d    = TOL;
`ifdef SB_SERVO_BISECT_EN
                  pstep_d  = {3{step_eff}};
                  dirv_d   = '0;
`else
                  step_d   = step_eff;
`endif
                  state_d  = S_SETTLE;
               end
            end
            S_SETTLE: begin
               prev_d = '0;
               if (strobe) begin
                  settle_d = ~settle_q;
                  if (settle_q) begin
                     win_d   = '0;
                     state_d = S_MEASURE;
                  end
               end
            end
            S_MEASURE: begin
               if (strobe) begin
                  for (int n = 0; n < 3; n++) begin
                     above = adc_q[n] > thres_q[n];
                     if (above && !prev_q[n] && !(&cnt_q[n]))
                        cnt_d[n] = cnt_q[n] + CNT_W'(1);
                     prev_d[n] = above;
                  end
                  if (win_q == window_q - WIN_W'(1)) begin
                     win_d   = '0;
                     state_d = S_ADJUST;
                  end else begin
                     win_d = win_q + WIN_W'(1);
                  end
               end
            end
            S_ADJUST: begin
               // Thresholds only move on a downsample boundary.
               if (strobe) begin
                  for (int n = 0; n < 3; n++) begin
                     if (!locked_q[n]) begin
                        up = {1'b0, cnt_q[n]} > hi_band;
                        dn = ({1'b0, cnt_q[n]} + {1'b0, tol_q}) < {1'b0, target_q};
`ifdef SB_SERVO_BISECT_EN
                        stp = pstep_q[n];
                        if ((up || dn) && dirv_q[n] && (dir_q[n] != up)) begin
                           stp_h = stp >> 1;
                           stp   = (stp_h == '0) ? ADC_W'(1) : stp_h;
                        end
                        pstep_d[n] = stp;
                        if (up || dn) begin
                           dir_d[n]  = up;
                           dirv_d[n] = 1'b1;
                        end
`else
                        stp = step_q;
`endif
                        sum = {1'b0, thres_q[n]} + {1'b0, stp};
                        if (up)
                           thres_d[n] = sum[ADC_W] ? '1 : sum[ADC_W-1:0];
                        else if (dn)
                           thres_d[n] = (thres_q[n] < stp) ? '0 : thres_q[n] - stp;
                        else
                           locked_d[n] = 1'b1;
                     end
                  end
                  iter_d  = iter_q + IT_W'(1);
                  state_d = S_CHECK;
               end
            end
            S_CHECK: begin
               if (locked_q == 3'b111) begin
                  fail_d  = 1'b0;
                  state_d = S_FINISH;
               end else if (iter_q == MAX_IT) begin
                  fail_d  = 1'b1;
                  state_d = S_FINISH;
               end else begin
                  cnt_d    = '0;
                  settle_d = 1'b0;
                  state_d  = S_SETTLE;
               end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // Servo state registers.
   always_ff @(posedge CLK120 or negedge RSTN) begin
      if (!RSTN) begin
         state_q  <= S_IDLE;
         thres_q  <= '0;
         cnt_q    <= '0;
         prev_q   <= '0;
         locked_q <= '0;
         fail_q   <= 1'b0;
         iter_q   <= '0;
         win_q    <= '0;
         settle_q <= 1'b0;
         window_q <= '0;
         target_q <= '0;
         tol_q    <= '0;
`ifdef SB_SERVO_BISECT_EN
         pstep_q  <= '0;
         dir_q    <= '0;
         dirv_q   <= '0;
`else
         step_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         thres_q  <= thres_d;
         cnt_q    <= cnt_d;
         prev_q   <= prev_d;
         locked_q <= locked_d;
         fail_q   <= fail_d;
         iter_q   <= iter_d;
         win_q    <= win_d;
         settle_q <= settle_d;
         window_q <= window_d;
         target_q <= target_d;
         tol_q    <= tol_d;
`ifdef SB_SERVO_BISECT_EN
         pstep_q  <= pstep_d;
         dir_q    <= dir_d;
         dirv_q   <= dirv_d;
`else
         step_q   <= step_d;
`endif
      end
   end

   assign THRES0 = thres_q[0];
   assign THRES1 = thres_q[1];
   assign THRES2 = thres_q[2];
   assign BUSY   = (state_q != S_IDLE);
   assign DONE   = (state_q == S_FINISH);
   assign LOCKED = locked_q;
   assign FAIL   = fail_q;

endmodule
